// File: rtl/udm_bus_responder.sv
// udm debug-bus target: word RAM plus ID / transaction / error registers,
// acking each request after a fixed number of wait states.
module udm_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned NUM_WORDS   = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hD1A0_0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_enb_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic [31:0] bus_rdata_bo
);

  localparam int unsigned AW        = $clog2(NUM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(NUM_WORDS * 4);
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ack_q;
  logic [31:0] rdata_q;
  logic [31:0] txn_q;
  logic [31:0] err_q;
  logic [31:0] mem_q [NUM_WORDS];

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] offset;
  logic [AW-1:0] word_idx;
  logic        hit_ram, hit_id, hit_txn, hit_err, err_access;
  logic        commit;
  logic [31:0] rd_d;

  // With zero wait states the commit happens on the capture edge itself, so
  // decode must look at the live bus rather than the not-yet-captured copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we    = bus_we_i;
      cur_addr  = bus_addr_bi;
      cur_wdata = bus_wdata_bi;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    offset     = cur_addr - BASE_ADDR;
    word_idx   = offset[AW+1:2];
    hit_ram    = (offset < RAM_BYTES);
    hit_id     = (offset[31:2] == 30'h400);
    hit_txn    = (offset[31:2] == 30'h401);
    hit_err    = (offset[31:2] == 30'h402);
    err_access = !(hit_ram || hit_id || hit_txn || hit_err);
    commit     = rst_i &&
                 (((state_q == S_IDLE) && bus_enb_i && (WAIT_CYCLES == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == 8'd1)));
  end

  always_comb begin
    rd_d = 32'hDEADBEEF;
    if (hit_ram)      rd_d = mem_q[word_idx];
    else if (hit_id)  rd_d = ID_VALUE;
    else if (hit_txn) rd_d = txn_q;
    else if (hit_err) rd_d = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (commit && cur_we && hit_ram) mem_q[word_idx] <= cur_wdata;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      txn_q   <= '0;
      err_q   <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_enb_i) begin
            we_q    <= bus_we_i;
            addr_q  <= bus_addr_bi;
            wdata_q <= bus_wdata_bi;
            cnt_q   <= WAIT_INIT;
            state_q <= (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_q <= S_ACK;
        end
        S_ACK:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (commit) begin
        ack_q <= 1'b1;
        txn_q <= txn_q + 32'd1;
        if (!cur_we) rdata_q <= rd_d;
        if (err_access) begin
          if (err_q != '1) err_q <= err_q + 32'd1;
        end else if (cur_we && hit_err) begin
          err_q <= '0;
        end
      end
    end
  end

  assign bus_ack_o    = ack_q;
  assign bus_rdata_bo = rdata_q;

endmodule

// File: tb/tb_udm_bus_responder.sv
// Directed bench for udm_bus_responder: two instances (offset base with wait
// states, zero base with no wait states) checked against a read-data scoreboard.
module tb_udm_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enb   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ack   [2];
  logic [31:0] rdata [2];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_rd [2];
  int unsigned lat [2];

  always #5 clk = ~clk;

  udm_bus_responder #(
    .BASE_ADDR  (32'h100),
    .NUM_WORDS  (256),
    .WAIT_CYCLES(2),
    .ID_VALUE   (32'hD1A0_0001)
  ) u_a (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bus_enb_i   (enb[0]),
    .bus_we_i    (we[0]),
    .bus_addr_bi (addr[0]),
    .bus_wdata_bi(wdata[0]),
    .bus_ack_o   (ack[0]),
    .bus_rdata_bo(rdata[0])
  );

  udm_bus_responder #(
    .BASE_ADDR  (32'h0),
    .NUM_WORDS  (4),
    .WAIT_CYCLES(0),
    .ID_VALUE   (32'hD1A0_0001)
  ) u_b (
    .clk_i       (clk),
    .rst_i       (rst_n),
    .bus_enb_i   (enb[1]),
    .bus_we_i    (we[1]),
    .bus_addr_bi (addr[1]),
    .bus_wdata_bi(wdata[1]),
    .bus_ack_o   (ack[1]),
    .bus_rdata_bo(rdata[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; reads push their expected data to the scoreboard.
  task automatic txn(input int s, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] exp, input string tag);
    int unsigned n;
    logic        got;
    logic [31:0] e;
    if (!w) exp_q.push_back(exp);
    enb[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      step();
      n++;
      if (ack[s]) got = 1'b1;
    end
    enb[s] = 1'b0;
    we[s] = 1'b0; addr[s] = 32'hFFFF_FFF0; wdata[s] = 32'h5A5A_5A5A;
    chk({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, n, lat[s]);
    if (!w) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, rdata[s], e);
      last_rd[s] = e;
    end else begin
      chk({tag, "_rdata_hold"}, rdata[s], last_rd[s]);
    end
    step();
    chk({tag, "_ack_pulse"}, {31'd0, ack[s]}, 32'd0);
  endtask

  initial begin
    int unsigned n;
    logic        got;
    logic [31:0] e;

    lat[0] = 3; lat[1] = 1;
    last_rd[0] = '0; last_rd[1] = '0;
    for (int i = 0; i < 2; i++) begin
      enb[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    rst_n = 1'b0;
    step(); step();
    chk("rst_ack_a",   {31'd0, ack[0]}, 32'd0);
    chk("rst_rdata_a", rdata[0], 32'd0);
    chk("rst_ack_b",   {31'd0, ack[1]}, 32'd0);
    chk("rst_rdata_b", rdata[1], 32'd0);
    rst_n = 1'b1;
    step();

    // Instance A: BASE 0x100, two wait states
    txn(0, 1'b1, 32'h110,  32'h1234_5678, '0, "wr_ram");
    txn(0, 1'b0, 32'h110,  '0, 32'h1234_5678, "rd_ram");
    txn(0, 1'b0, 32'h1100, '0, 32'hD1A0_0001, "rd_id");
    txn(0, 1'b1, 32'h104,  32'h0000_0011, '0, "wr_ram4");
    txn(0, 1'b1, 32'h108,  32'h0000_0022, '0, "wr_ram8");
    txn(0, 1'b0, 32'h1104, '0, 32'd5, "rd_txn5");
    txn(0, 1'b0, 32'h2100, '0, 32'hDEAD_BEEF, "rd_oor");
    txn(0, 1'b0, 32'h1108, '0, 32'd1, "rd_err1");
    txn(0, 1'b1, 32'h1108, 32'd0, '0, "clr_err");
    txn(0, 1'b0, 32'h1108, '0, 32'd0, "rd_err0");
    txn(0, 1'b0, 32'h80,   '0, 32'hDEAD_BEEF, "rd_below_base");
    txn(0, 1'b1, 32'h100,  32'hCAFE_F00D, '0, "wr_off0");
    txn(0, 1'b0, 32'h103,  '0, 32'hCAFE_F00D, "rd_alias");
    txn(0, 1'b1, 32'h1100, 32'h1111_1111, '0, "wr_id");
    txn(0, 1'b0, 32'h1100, '0, 32'hD1A0_0001, "rd_id_kept");
    txn(0, 1'b0, 32'h1108, '0, 32'd1, "rd_err_after_id_wr");
    txn(0, 1'b0, 32'h104,  '0, 32'h0000_0011, "rd_ram4");

    // Reset in the middle of a write's wait phase
    enb[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h120; wdata[0] = 32'hAAAA_5555;
    step();
    chk("abort_wait1_ack", {31'd0, ack[0]}, 32'd0);
    step();
    chk("abort_wait2_ack", {31'd0, ack[0]}, 32'd0);
    rst_n = 1'b0;
    step();
    chk("abort_rst_ack", {31'd0, ack[0]}, 32'd0);
    chk("abort_rst_rdata", rdata[0], 32'd0);
    enb[0] = 1'b0;
    step();
    rst_n = 1'b1;
    last_rd[0] = '0; last_rd[1] = '0;
    step();
    chk("abort_no_ack", {31'd0, ack[0]}, 32'd0);
    txn(0, 1'b0, 32'h1104, '0, 32'd0, "rd_txn_after_rst");
    txn(0, 1'b0, 32'h1108, '0, 32'd0, "rd_err_after_rst");
    txn(0, 1'b1, 32'h120,  32'd0, '0, "wr_reinit");
    txn(0, 1'b0, 32'h120,  '0, 32'd0, "rd_reinit");

    // Instance B: zero wait states, then enb held high across three reads
    txn(1, 1'b1, 32'h0, 32'h0000_00A1, '0, "b_wr0");
    txn(1, 1'b1, 32'h4, 32'h0000_00B2, '0, "b_wr1");
    txn(1, 1'b1, 32'h8, 32'h0000_00C3, '0, "b_wr2");
    txn(1, 1'b0, 32'h10, '0, 32'hDEAD_BEEF, "b_rd_oor");
    exp_q.push_back(32'h0000_00A1);
    exp_q.push_back(32'h0000_00B2);
    exp_q.push_back(32'h0000_00C3);
    enb[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
        step();
        n++;
        if (ack[1]) got = 1'b1;
      end
      chk($sformatf("b2b_ack_seen%0d", i), {31'd0, got}, 32'd1);
      chk($sformatf("b2b_spacing%0d", i), n, (i == 0) ? 32'd1 : 32'd2);
      e = exp_q.pop_front();
      chk($sformatf("b2b_rdata%0d", i), rdata[1], e);
      addr[1] = 32'(4 * (i + 1));
      if (i == 2) enb[1] = 1'b0;
    end
    step();
    chk("b2b_no_extra_ack", {31'd0, ack[1]}, 32'd0);
    step();
    chk("b2b_idle_ack", {31'd0, ack[1]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
